// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer. It registers one request, drives the data memory and returns a registered response.
// Optional macro SPLIT_UNALIGNED_EN turns an unaligned word access into two byte accesses. Without it, the access is rejected.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ACC0  | first (or only) memory cycle; unaligned reject waits here with memory idle
// ACC1  | second byte of a split unaligned word access
// RESP  | resp_valid pulse, memory idle
module load_store_unit #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              misalign_err,
   output logic              dm_memWrite,
   output logic              dm_byte_en,
   output logic [ADDR_W-1:0] dm_address,
   output logic [DATA_W-1:0] dm_writeData,
   input  logic [DATA_W-1:0] dm_readData
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t              state_q, state_d;
   logic                write_q, write_d;
   logic                byte_q, byte_d;
   logic                unal_q, unal_d;
   logic                mem_write_q, mem_write_d;
   logic                byte_en_q, byte_en_d;
   logic [ADDR_W-1:0]   address_q, address_d;
   logic [DATA_W-1:0]   write_data_q, write_data_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                misalign_q, misalign_d;
`ifdef SPLIT_UNALIGNED_EN
   logic [7:0]          wdata_hi_q, wdata_hi_d;
`endif

   logic                req_unal;

   assign req_unal = ~req_byte & req_addr[0];

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      byte_d       = byte_q;
      unal_d       = unal_q;
      mem_write_d  = mem_write_q;
      byte_en_d    = byte_en_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      rdata_d      = rdata_q;
      misalign_d   = misalign_q;
`ifdef SPLIT_UNALIGNED_EN
      wdata_hi_d   = wdata_hi_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               byte_d     = req_byte;
               unal_d     = req_unal;
               address_d  = req_addr;
               rdata_d    = '0;
               misalign_d = 1'b0;
               state_d    = ACC0;
               if (req_unal) begin
`ifdef SPLIT_UNALIGNED_EN
                  wdata_hi_d   = req_wdata[15:8];
                  byte_en_d    = 1'b1;
                  mem_write_d  = req_write;
                  write_data_d = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
`else
                  byte_en_d    = 1'b0;
                  mem_write_d  = 1'b0;
                  write_data_d = '0;
`endif
               end else begin
                  byte_en_d    = req_byte;
                  mem_write_d  = req_write;
                  write_data_d = req_byte ? {{(DATA_W-8){1'b0}}, req_wdata[7:0]} : req_wdata;
               end
            end
         end
         ACC0: begin
            if (unal_q) begin
`ifdef SPLIT_UNALIGNED_EN
               if (!write_q) rdata_d = {{(DATA_W-8){1'b0}}, dm_readData[7:0]};
               address_d    = address_q + ADDR_W'(1);
               write_data_d = {{(DATA_W-8){1'b0}}, wdata_hi_q};
               state_d      = ACC1;
`else
               misalign_d  = 1'b1;
               mem_write_d = 1'b0;
               byte_en_d   = 1'b0;
               state_d     = RESP;
`endif
            end else begin
               if (!write_q)
                  rdata_d = byte_q ? {{(DATA_W-8){1'b0}}, dm_readData[7:0]} : dm_readData;
               mem_write_d = 1'b0;
               byte_en_d   = 1'b0;
               state_d     = RESP;
            end
         end
         ACC1: begin
            // high byte of a split load lands on top of the low byte from ACC0
            if (!write_q) rdata_d[15:8] = dm_readData[7:0];
            mem_write_d = 1'b0;
            byte_en_d   = 1'b0;
            state_d     = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         byte_q       <= 1'b0;
         unal_q       <= 1'b0;
         mem_write_q  <= 1'b0;
         byte_en_q    <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         rdata_q      <= '0;
         misalign_q   <= 1'b0;
`ifdef SPLIT_UNALIGNED_EN
         wdata_hi_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         byte_q       <= byte_d;
         unal_q       <= unal_d;
         mem_write_q  <= mem_write_d;
         byte_en_q    <= byte_en_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         rdata_q      <= rdata_d;
         misalign_q   <= misalign_d;
`ifdef SPLIT_UNALIGNED_EN
         wdata_hi_q   <= wdata_hi_d;
`endif
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign resp_valid   = (state_q == RESP);
   assign resp_rdata   = rdata_q;
   assign misalign_err = resp_valid & misalign_q;
   assign dm_memWrite  = mem_write_q;
   assign dm_byte_en   = byte_en_q;
   assign dm_address   = address_q;
   assign dm_writeData = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit paired with a byte-addressed data memory model.
// Honours SPLIT_UNALIGNED_EN the same way the design does.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_write, req_byte;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, misalign_err;
   logic [15:0] resp_rdata;
   logic        dm_memWrite, dm_byte_en;
   logic [15:0] dm_address, dm_writeData, dm_readData;
   logic [15:0] rd_hi_addr;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          delta;
      int          acc;
      int          mw;
      int          be;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   mw_cnt = 0;
   int   be_cnt = 0;

   load_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
      .dm_memWrite(dm_memWrite), .dm_byte_en(dm_byte_en), .dm_address(dm_address),
      .dm_writeData(dm_writeData), .dm_readData(dm_readData)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rd_hi_addr  = dm_address + 16'd1;
   assign dm_readData = {mem[rd_hi_addr], mem[dm_address]};

   always @(negedge clk) begin
      if (rst_n && dm_memWrite) begin
         mem[dm_address] = dm_writeData[7:0];
         if (!dm_byte_en) mem[rd_hi_addr] = dm_writeData[15:8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on every response and checks phase rules
   always @(negedge clk) begin
      if (!rst_n) begin
         mw_cnt = 0;
         be_cnt = 0;
      end else begin
         if (dm_memWrite) mw_cnt++;
         if (dm_byte_en) be_cnt++;
         chk("memwrite_outside_access", {31'd0, dm_memWrite & (req_ready | resp_valid)}, 32'd0);
         if (misalign_err && !resp_valid) chk("misalign_without_resp", 32'd1, 32'd0);
         if (resp_valid) begin
            chk("resp_expected", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, mon_e.rdata});
               chk("misalign_err", {31'd0, misalign_err}, {31'd0, mon_e.err});
               chk("resp_latency", cyc - mon_e.acc, mon_e.delta);
               chk("memwrite_cycles", mw_cnt, mon_e.mw);
               chk("byte_en_cycles", be_cnt, mon_e.be);
            end
            mw_cnt = 0;
            be_cnt = 0;
         end
      end
   end

   task automatic do_req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
      int          guard;
      logic [15:0] a1;
      logic        unal, split, rej;
      exp_t        e;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      a1    = a + 16'd1;
      unal  = !b && a[0];
`ifdef SPLIT_UNALIGNED_EN
      split = unal;
      rej   = 1'b0;
`else
      split = 1'b0;
      rej   = unal;
`endif
      e.acc = cyc;
      if (rej) begin
         e.rdata = 16'h0000; e.err = 1'b1; e.delta = 1; e.mw = 0; e.be = 0;
      end else begin
         e.err   = 1'b0;
         e.delta = split ? 2 : 1;
         e.be    = split ? 2 : (b ? 1 : 0);
         if (w) begin
            ref_mem[a] = d[7:0];
            if (!b) ref_mem[a1] = d[15:8];
            e.rdata = 16'h0000;
            e.mw    = split ? 2 : 1;
         end else begin
            e.rdata = b ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
            e.mw    = 0;
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while ((sb_q.size() != 0 || !req_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [7:0] pre [0:9];
      int r, diffs;
      logic [15:0] ra;
      pre = '{8'h56, 8'h38, 8'h00, 8'h00, 8'h12, 8'h43, 8'hDE, 8'hBE, 8'hEF, 8'hAD};
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      for (int i = 0; i < 10; i++) begin
         mem[i] = pre[i];
         ref_mem[i] = pre[i];
      end
      req_valid = 0; req_write = 0; req_byte = 0; req_addr = 0; req_wdata = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
      chk("rst_dm_outputs", {dm_memWrite, dm_byte_en, dm_address, dm_writeData[13:0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_req(1'b0, 1'b0, 16'h0004, 16'h0000);
      @(negedge clk);
      chk("ready_low_acc", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("ready_low_resp", {31'd0, req_ready}, 32'd0);

      do_req(1'b0, 1'b1, 16'h0009, 16'h0000);
      do_req(1'b1, 1'b0, 16'h0002, 16'hCAFE);
      do_req(1'b0, 1'b0, 16'h0002, 16'h0000);
      wait_idle();
      chk("store_byte2", {24'd0, mem[2]}, 32'hFE);
      chk("store_byte3", {24'd0, mem[3]}, 32'hCA);

      do_req(1'b0, 1'b0, 16'h0005, 16'h0000);
      wait_idle();

`ifdef SPLIT_UNALIGNED_EN
      do_req(1'b1, 1'b0, 16'hFFFF, 16'h1234);
      @(negedge clk);
      chk("split_acc0_addr", {16'd0, dm_address}, 32'hFFFF);
      @(negedge clk);
      chk("split_acc1_addr", {16'd0, dm_address}, 32'h0000);
      chk("split_acc1_write", {31'd0, dm_memWrite}, 32'd1);
      wait_idle();
      chk("wrap_byte_ffff", {24'd0, mem[16'hFFFF]}, 32'h34);
      chk("wrap_byte_0000", {24'd0, mem[0]}, 32'h12);
`endif

      // abandon a store in ACC0 with reset; it must leave no response and no write
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h000A; req_wdata = 16'h5555;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("abort_in_acc0", {31'd0, dm_memWrite}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_memwrite_drop", {31'd0, dm_memWrite}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 1'b0, 16'h000A, 16'h0000);
      wait_idle();

      for (int n = 0; n < 200; n++) begin
         r  = $urandom_range(0, 31);
         ra = (r < 16) ? 16'(r) : 16'hFFF0 + 16'(r - 16);
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom));
      end
      wait_idle();

      diffs = 0;
      for (int i = 0; i < 65536; i++)
         if (mem[i] !== ref_mem[i]) diffs++;
      chk("final_memory_image", diffs, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store sequencer of the 16-bit CPU; sits directly upstream of the data memory.
- Accepts one load/store request per transaction from the EX/MEM pipeline register.
- Drives the data memory's memWrite/byte_en/address/writeData.
- Captures readData and returns a registered response, stalling the pipeline while busy.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width; the byte lane is always [7:0].

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
- req_valid  input  1  request present.
- req_write  input  1  1 = store, 0 = load.
- req_byte  input  1  1 = byte access (lbu/sb), 0 = word.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data.
- req_ready  output  1  1 only in IDLE; the pipeline stalls when 0.
- resp_valid  output  1  one-cycle pulse when the transaction completes (loads and stores).
- resp_rdata  output  DATA_W  load result; byte loads are zero-extended; 0 for stores.
- misalign_err  output  1  pulses with resp_valid for a rejected unaligned word access.
- dm_memWrite  output  1  to data memory memWrite.
- dm_byte_en  output  1  to data memory byte_en.
- dm_address  output  ADDR_W  to data memory address.
- dm_writeData  output  DATA_W  to data memory writeData.
- dm_readData  input  DATA_W  from data memory readData (combinational from dm_address).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, misalign_err = 0.
  - All dm_* outputs = 0.
- Registers: all dm_* outputs are registered, so no combinational path runs from req_* to dm_*.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - A request is accepted on the edge where req_valid = 1 and req_ready = 1.
  - On accept, the request is latched, the dm_* signals are loaded and the FSM moves to ACC0.
  - req_valid with req_ready = 0 is ignored; the requester holds it.
- ACC0, aligned word (req_addr[0] = 0) or any byte:
  - dm_address = addr, dm_byte_en = req_byte, dm_memWrite = req_write.
  - dm_writeData = req_wdata for a word; {8'h00, req_wdata[7:0]} for a byte.
  - Loads capture dm_readData at the end of ACC0: the full word for a word load, {8'h00, dm_readData[7:0]} for a byte load.
  - Next state: RESP.
- ACC0/ACC1, unaligned word: handling depends on the optional feature.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - dm_memWrite = 0, dm_byte_en = 0.
  - Next state: IDLE, with req_ready = 1.
- Latency:
  - Accept at edge N; memory is driven during cycle N+1; resp_valid is high in cycle N+2.
  - Split access: resp_valid is high in cycle N+3.
- Throughput: one transaction per 3 cycles (4 when split).
- dm_memWrite is high only in ACC0/ACC1 for stores; it is never high in IDLE or RESP.
- Address arithmetic is modulo 2^16: addr 0xFFFF + 1 = 0x0000.
- Reset asserted mid-transaction:
  - The transaction is abandoned with no response.
  - dm_memWrite drops asynchronously.
  - A split store may leave only its low byte written; this is accepted.

Optional Feature:
- Macro: SPLIT_UNALIGNED_EN.
- Defined: an unaligned word access (req_byte = 0, addr[0] = 1) becomes two byte accesses.
  - ACC0: address addr, byte_en = 1, write {8'h00, wdata[7:0]}; loads capture the low byte.
  - ACC1: address addr+1 (wrapping), byte_en = 1, write {8'h00, wdata[15:8]}; loads capture the high byte.
  - Then RESP with misalign_err = 0.
- Undefined: an unaligned word access skips ACC0/ACC1 and goes to RESP one cycle after accept.
  - No memory cycle is issued (dm_memWrite stays 0).
  - resp_rdata = 0, misalign_err = 1 with resp_valid.

Test Plan:
- Setup: the bench pairs the block with a data memory model preloaded with bytes 0x0000..0x0009 = 56 38 00 00 12 43 DE BE EF AD.
- Aligned word load at 0x0004, accepted at edge N -> resp_valid in cycle N+2, resp_rdata = 0x4312, misalign_err = 0; req_ready = 0 in cycles N+1 and N+2.
- Byte load at 0x0009 -> resp_rdata = 0x00AD; dm_byte_en = 1 during ACC0.
- Word store 0xCAFE at 0x0002, then word load at 0x0002 -> memory bytes [2] = FE, [3] = CA; load returns 0xCAFE; dm_memWrite high for exactly one cycle.
- Word load at 0x0005:
  - With SPLIT_UNALIGNED_EN -> two byte accesses at 0x0005 and 0x0006; resp_rdata = 0xDE43 in cycle N+3.
  - Without it -> resp_rdata = 0, misalign_err = 1 in cycle N+2; dm_memWrite never asserted.
- Word store 0x1234 at 0xFFFF with SPLIT_UNALIGNED_EN -> ACC1 drives dm_address = 0x0000; bytes [FFFF] = 34, [0000] = 12.
- reset driven low during ACC0 of a store -> dm_memWrite = 0 and req_ready = 1 immediately; no resp_valid; the next request after release completes normally.
